// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE control path: sequencer states and pipeline depth.
package pe_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONFIG,
      MAC,
      NEXT_WIN,
      NEXT_ROW,
      DRAIN,
      DONE
   } pe_state_t;

   // Cycles from the last MAC issue until the final psum lands in the psum FIFO.
   localparam int PE_PIPE_DEPTH = 3;

endpackage : pe_ctrl_pkg

// File: rtl/pe_sequencer_counter.sv
// Generic up-counter with synchronous clear; clear takes priority over enable.
module pe_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise step by one when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : pe_counter

// File: rtl/pe_sequencer.sv
// Control FSM for one PE datapath: configures stride/filter size, issues MAC
// steps while both scratch-pad operands are present, steps windows and rows,
// then drains the multiply/accumulate pipeline before signalling completion.
module pe_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int ROW_CNT_WIDTH = 8,
   parameter int PIPE_DEPTH    = PE_PIPE_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ROW_CNT_WIDTH-1:0] num_rows,
   input  logic                     av_data,
   input  logic                     av_filter,
   input  logic                     end_of_filter,
   input  logic                     end_of_row,
   output logic                     ld_stride,
   output logic                     ld_filterSize,
   output logic                     put_data,
   output logic                     put_filter,
   output logic                     clear_sum,
   output logic                     next_filter,
   output logic                     next_row,
   output logic                     busy,
   output logic                     done
);

   localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) + 1 : 1;

   pe_state_t                state_q;
   pe_state_t                state_d;
   logic                     first_mac_q;
   logic                     first_mac_d;
   logic [ROW_CNT_WIDTH-1:0] rows_m1_q;
   logic [ROW_CNT_WIDTH-1:0] rows_m1_d;

   logic [ROW_CNT_WIDTH-1:0] row_cnt;
   logic                     row_clr;
   logic                     row_en;
   logic [DRAIN_W-1:0]       drain_cnt;
   logic                     drain_clr;
   logic                     drain_en;
   logic                     go;

   assign go = av_data && av_filter;

   // Row index inside the job; compared by equality so a full-scale row count never wraps.
   pe_counter #(
      .W (ROW_CNT_WIDTH)
   ) u_row_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (row_clr),
      .en_i  (row_en),
      .cnt_o (row_cnt)
   );

   // Cycles spent flushing the datapath after the last issue.
   pe_counter #(
      .W (DRAIN_W)
   ) u_drain_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (drain_clr),
      .en_i  (drain_en),
      .cnt_o (drain_cnt)
   );

   // Next-state and output decode; put_*/clear_sum follow operand availability in MAC.
   always_comb begin
      state_d       = state_q;
      first_mac_d   = first_mac_q;
      rows_m1_d     = rows_m1_q;
      row_clr       = 1'b0;
      row_en        = 1'b0;
      drain_clr     = 1'b0;
      drain_en      = 1'b0;
      ld_stride     = 1'b0;
      ld_filterSize = 1'b0;
      put_data      = 1'b0;
      put_filter    = 1'b0;
      clear_sum     = 1'b0;
      next_filter   = 1'b0;
      next_row      = 1'b0;
      done          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CONFIG;
            end
         end

         CONFIG: begin
            ld_stride     = 1'b1;
            ld_filterSize = 1'b1;
            // A zero row count runs a single row.
            rows_m1_d     = (num_rows == '0) ? '0 : num_rows - ROW_CNT_WIDTH'(1);
            row_clr       = 1'b1;
            first_mac_d   = 1'b1;
            state_d       = MAC;
         end

         MAC: begin
            if (go) begin
               put_data    = 1'b1;
               put_filter  = 1'b1;
               clear_sum   = first_mac_q;
               first_mac_d = 1'b0;
               if (end_of_filter) begin
                  state_d = end_of_row ? NEXT_ROW : NEXT_WIN;
               end
            end
         end

         NEXT_WIN: begin
            next_filter = 1'b1;
            first_mac_d = 1'b1;
            state_d     = MAC;
         end

         NEXT_ROW: begin
            next_row    = 1'b1;
            next_filter = 1'b1;
            first_mac_d = 1'b1;
            if (row_cnt == rows_m1_q) begin
               drain_clr = 1'b1;
               state_d   = DRAIN;
            end else begin
               row_en  = 1'b1;
               state_d = MAC;
            end
         end

         DRAIN: begin
            drain_en = 1'b1;
            if (drain_cnt == DRAIN_W'(PIPE_DEPTH - 1)) begin
               state_d = DONE;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);

   // State and window-start flag; reset aborts any job straight back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         first_mac_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         first_mac_q <= first_mac_d;
      end
   end

   // Last-row index captured once per job.
   always_ff @(posedge clk) begin
      rows_m1_q <= rows_m1_d;
   end

endmodule : pe_sequencer
